// File: rtl/writeback_group_arbiter_if.sv
// Writeback group bus: unit done/ack side plus the shared register-file
// writeback port.
interface writeback_group_arbiter_if #(
  parameter int NUM_UNITS = 4,
  parameter int ID_W      = 3,
  parameter int DATA_W    = 32,
  parameter int PHYS_W    = 6
);
  localparam int GW = $clog2(NUM_UNITS);

  logic [NUM_UNITS-1:0]        unit_done;
  logic [NUM_UNITS*ID_W-1:0]   unit_id;
  logic [NUM_UNITS*DATA_W-1:0] unit_data;
  logic [NUM_UNITS*PHYS_W-1:0] unit_phys_rd;
  logic [NUM_UNITS-1:0]        unit_ack;
  logic                        wb_valid;
  logic [ID_W-1:0]             wb_id;
  logic [DATA_W-1:0]           wb_data;
  logic [PHYS_W-1:0]           wb_phys_rd;
  logic                        wb_ready;
  logic [GW-1:0]               wb_grant_unit;

  modport slave (
    input  unit_done, unit_id, unit_data,
    input  unit_phys_rd, wb_ready,
    output unit_ack, wb_valid, wb_id,
    output wb_data, wb_phys_rd, wb_grant_unit
  );

  modport master (
    output unit_done, unit_id, unit_data,
    output unit_phys_rd, wb_ready,
    input  unit_ack, wb_valid, wb_id,
    input  wb_data, wb_phys_rd, wb_grant_unit
  );
endinterface

// File: rtl/writeback_group_arbiter.sv
// Round-robin arbiter sharing one registered writeback port
// among the execution units of a writeback group.
module writeback_group_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int ID_W      = 3,
  parameter int DATA_W    = 32,
  parameter int PHYS_W    = 6
) (
  input logic                      clk,
  input logic                      rst,
  writeback_group_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_UNITS);
  typedef logic [GW-1:0] idx_t;

  logic              valid_q, valid_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [PHYS_W-1:0] phys_q, phys_d;
  idx_t              grant_q, grant_d;
  idx_t              ptr_q, ptr_d;

  logic                 load_en;
  logic                 found;
  logic                 grant;
  idx_t                 gnt;
  logic [GW:0]          sum;
  logic [NUM_UNITS-1:0] ack;

  assign load_en = !valid_q || bus.wb_ready;
  assign grant   = found && load_en && !rst;

  // Rotating scan: first done unit at or after the pointer wins
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    sum   = '0;
    for (int j = 0; j < NUM_UNITS; j++) begin
      sum = {1'b0, ptr_q} + (GW+1)'(j);
      if (sum >= (GW+1)'(NUM_UNITS))
        sum = sum - (GW+1)'(NUM_UNITS);
      if (!found && bus.unit_done[sum[GW-1:0]]) begin
        found = 1'b1;
        gnt   = sum[GW-1:0];
      end
    end
  end

  always_comb begin
    ack = '0;
    if (grant) ack[gnt] = 1'b1;
  end

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    data_d  = data_q;
    phys_d  = phys_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      valid_d = found;
      if (found) begin
        id_d    = bus.unit_id[gnt*ID_W +: ID_W];
        data_d  = bus.unit_data[gnt*DATA_W +: DATA_W];
        phys_d  = bus.unit_phys_rd[gnt*PHYS_W +: PHYS_W];
        grant_d = gnt;
        ptr_d   = (gnt == idx_t'(NUM_UNITS-1)) ?
                  '0 : gnt + idx_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
      phys_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      data_q  <= data_d;
      phys_q  <= phys_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.unit_ack      = ack;
  assign bus.wb_valid      = valid_q;
  assign bus.wb_id         = id_q;
  assign bus.wb_data       = data_q;
  assign bus.wb_phys_rd    = phys_q;
  assign bus.wb_grant_unit = grant_q;

  a_ack_onehot: assert property (
    @(posedge clk) $onehot0(ack));

  a_ack_done: assert property (
    @(posedge clk) (ack & ~bus.unit_done) == '0);

  a_stall_stable: assert property (
    @(posedge clk) disable iff (rst)
    (valid_q && !bus.wb_ready) |=>
      $stable({valid_q, id_q, data_q, phys_q, grant_q}));
endmodule

// File: tb/tb_writeback_group_arbiter.sv
// Randomized and directed bench for writeback_group_arbiter
// against a cycle-level reference model.
module tb_writeback_group_arbiter;
  localparam int N  = 4;
  localparam int IW = 3;
  localparam int DW = 32;
  localparam int PW = 6;

  logic clk = 1'b0;
  logic rst;

  writeback_group_arbiter_if #(
    .NUM_UNITS(N), .ID_W(IW), .DATA_W(DW), .PHYS_W(PW)
  ) bus ();

  writeback_group_arbiter #(
    .NUM_UNITS(N), .ID_W(IW), .DATA_W(DW), .PHYS_W(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int            mP;
  int            mg;
  bit            mv;
  bit            mz;
  logic [IW-1:0] mid;
  logic [DW-1:0] mdat;
  logic [PW-1:0] mph;
  logic [N-1:0]  eack;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_unit(int i, bit d, logic [IW-1:0] id,
                          logic [DW-1:0] dat, logic [PW-1:0] ph);
    bus.unit_done[i]          = d;
    bus.unit_id[i*IW +: IW]   = id;
    bus.unit_data[i*DW +: DW] = dat;
    bus.unit_phys_rd[i*PW +: PW] = ph;
  endtask

  task automatic rnd_unit(int i);
    set_unit(i, 1'b1, IW'($urandom), $urandom, PW'($urandom));
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) set_unit(i, 1'b0, '0, '0, '0);
  endtask

  // Acked units re-present with pct_keep, idle units raise with pct_new
  task automatic refresh(int pct_keep, int pct_new);
    for (int i = 0; i < N; i++) begin
      if (eack[i]) begin
        if ($urandom_range(99) < pct_keep) rnd_unit(i);
        else bus.unit_done[i] = 1'b0;
      end else if (!bus.unit_done[i] &&
                   $urandom_range(99) < pct_new) begin
        rnd_unit(i);
      end
    end
  endtask

  // One clock: check combinational ack, advance model, check port
  task automatic step();
    int k;
    k = -1;
    eack = '0;
    #1;
    if (!rst && (!mv || bus.wb_ready)) begin
      for (int j = 0; j < N; j++)
        if (k < 0 && bus.unit_done[(mP + j) % N]) k = (mP + j) % N;
    end
    if (k >= 0) eack[k] = 1'b1;
    check("unit_ack", bus.unit_ack, eack);
    if (rst) begin
      mv = 0; mz = 1; mP = 0; mg = 0;
      mid = '0; mdat = '0; mph = '0;
    end else if (!mv || bus.wb_ready) begin
      if (k >= 0) begin
        mv   = 1;
        mz   = 0;
        mg   = k;
        mP   = (k + 1) % N;
        mid  = bus.unit_id[k*IW +: IW];
        mdat = bus.unit_data[k*DW +: DW];
        mph  = bus.unit_phys_rd[k*PW +: PW];
      end else begin
        mv = 0;
      end
    end
    @(posedge clk);
    #1;
    check("wb_valid", bus.wb_valid, mv);
    if (mv || mz) begin
      check("wb_id", bus.wb_id, mid);
      check("wb_data", bus.wb_data, mdat);
      check("wb_phys_rd", bus.wb_phys_rd, mph);
      check("wb_grant_unit", bus.wb_grant_unit, mg);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.wb_ready = 1'b1;
    mv = 0; mz = 0; mP = 0; mg = 0;
    mid = '0; mdat = '0; mph = '0;
    clr();
    step();
    step();
    check("rst_valid", bus.wb_valid, 0);
    rst = 1'b0;

    // single requester, then idle drain
    set_unit(2, 1'b1, 3'd5, 32'hDEADBEEF, 6'd12);
    step();
    check("single_id", bus.wb_id, 5);
    check("single_data", bus.wb_data, 32'hDEADBEEF);
    check("single_phys", bus.wb_phys_rd, 12);
    check("single_grant", bus.wb_grant_unit, 2);
    set_unit(2, 1'b0, '0, '0, '0);
    step();
    check("drain_valid", bus.wb_valid, 0);

    // round robin with all units continuously done
    do_reset();
    for (int i = 0; i < N; i++) rnd_unit(i);
    for (int c = 0; c < 5; c++) begin
      step();
      check("rr_grant", bus.wb_grant_unit, c % N);
      check("rr_valid", bus.wb_valid, 1);
      refresh(100, 0);
    end

    // backpressure
    do_reset();
    clr();
    rnd_unit(1);
    step();
    check("bp_first", bus.wb_grant_unit, 1);
    bus.unit_done[1] = 1'b0;
    rnd_unit(3);
    bus.wb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_hold", bus.wb_grant_unit, 1);
    end
    bus.wb_ready = 1'b1;
    step();
    check("bp_next", bus.wb_grant_unit, 3);
    bus.unit_done[3] = 1'b0;

    // wrap-around from pointer 0 after unit 3
    rnd_unit(0);
    rnd_unit(3);
    step();
    check("wrap_first", bus.wb_grant_unit, 0);
    bus.unit_done[0] = 1'b0;
    step();
    check("wrap_second", bus.wb_grant_unit, 3);
    clr();

    // reset during a stall
    rnd_unit(1);
    step();
    rnd_unit(1);
    rnd_unit(2);
    bus.wb_ready = 1'b0;
    step();
    check("stall_valid", bus.wb_valid, 1);
    rst = 1'b1;
    step();
    check("rst_stall_valid", bus.wb_valid, 0);
    rst = 1'b0;
    bus.wb_ready = 1'b1;
    step();
    check("rst_first_grant", bus.wb_grant_unit, 1);
    clr();

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      bus.wb_ready = ($urandom_range(99) < 70);
      rst = ($urandom_range(99) < 2);
      step();
      refresh(40, 35);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
